// File: rtl/decode_pkg.sv
// Shared decode definitions: uop codes, instruction field positions, FSM states and bundle types.
package decode_pkg;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_B   = 5'd9;

  localparam int unsigned UOP_LSB    = 27;
  localparam int unsigned COND_LSB   = 23;
  localparam int unsigned SEL_IN_LSB = 19;
  localparam int unsigned SEL_P0_LSB = 15;
  localparam int unsigned SEL_P1_LSB = 11;
  localparam int unsigned IMM_BIT    = 10;
  localparam int unsigned EXT_BIT    = 9;
  localparam int unsigned IMM9_LSB   = 0;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] uop;
    logic [3:0] branch_cond;
    logic [3:0] sel_in;
    logic [3:0] sel_p0;
    logic [3:0] sel_p1;
    logic       imm;
    logic       ext;
    logic [8:0] imm9;
  } fields_t;

  typedef struct packed {
    logic        num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0;
    logic [3:0]  sel_p1;
    logic [3:0]  sel_in;
    logic [4:0]  uop;
    logic [3:0]  branch_cond;
  } bundle_t;

  function automatic logic uop_legal(input logic [4:0] uop);
    return uop inside {UOP_NOP, UOP_ADD, 5'd2, UOP_AND, 5'd4, UOP_CMP, UOP_MOV, UOP_B};
  endfunction

  function automatic bundle_t to_bundle(input fields_t f, input logic ntr, input logic [31:0] num);
    bundle_t b;
    b.num_to_rhs  = ntr;
    b.num         = num;
    b.sel_p0      = f.sel_p0;
    b.sel_p1      = f.sel_p1;
    b.sel_in      = f.sel_in;
    b.uop         = f.uop;
    b.branch_cond = f.branch_cond;
    return b;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Purely combinational split of a 32-bit instruction word into its decode fields.
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output fields_t     fields
);

  always_comb begin
    fields.uop         = instr[UOP_LSB +: 5];
    fields.branch_cond = instr[COND_LSB +: 4];
    fields.sel_in      = instr[SEL_IN_LSB +: 4];
    fields.sel_p0      = instr[SEL_P0_LSB +: 4];
    fields.sel_p1      = instr[SEL_P1_LSB +: 4];
    fields.imm         = instr[IMM_BIT];
    fields.ext         = instr[EXT_BIT];
    fields.imm9        = instr[IMM9_LSB +: 9];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: turns fetch words (one- or two-word) into the registered Execute control bundle.
// Optional illegal-uop trap is enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        global_disable,
  output logic        num_to_rhs,
  output logic [31:0] num,
  output logic [3:0]  sel_p0,
  output logic [3:0]  sel_p1,
  output logic [3:0]  sel_in,
  output logic [4:0]  uop,
  output logic [3:0]  branch_cond,
  output logic        illegal
);

  localparam int unsigned CntW = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

  fields_t         f;
  state_e          state_q, state_d;
  fields_t         pend_q, pend_d;
  logic [CntW-1:0] flush_q, flush_d;
  bundle_t         out_q, out_d;
  bundle_t         cand;
  logic            emit;
  logic            accept;

  decode_fields u_fields (
    .instr  (instr),
    .fields (f)
  );

  // Execute never stalls, so the only time words are refused is while in reset.
  assign instr_ready = ~rst;
  assign accept      = instr_valid & instr_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    flush_d = flush_q;
    out_d   = '0;
    cand    = '0;
    emit    = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (global_disable) begin
      state_d = S_OP;
      pend_d  = '0;
      flush_d = CntW'(FLUSH_DEPTH);
    end else if (flush_q != '0) begin
      // Branch shadow: any word, opcode or immediate alike, is dropped here.
      if (accept) flush_d = flush_q - CntW'(1);
    end else if (accept) begin
      unique case (state_q)
        S_IMM: begin
          cand    = to_bundle(pend_q, 1'b1, instr);
          emit    = 1'b1;
          state_d = S_OP;
          pend_d  = '0;
        end
        default: begin
          if (f.imm && f.ext) begin
            pend_d  = f;
            state_d = S_IMM;
          end else begin
            cand = to_bundle(f, f.imm, f.imm ? {23'b0, f.imm9} : 32'b0);
            emit = 1'b1;
          end
        end
      endcase
    end

    if (emit) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (uop_legal(cand.uop)) out_d = cand;
      else illegal_d = 1'b1;
`else
      out_d = cand;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OP;
      pend_q  <= '0;
      flush_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      out_q   <= out_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign num_to_rhs  = out_q.num_to_rhs;
  assign num         = out_q.num;
  assign sel_p0      = out_q.sel_p0;
  assign sel_p1      = out_q.sel_p1;
  assign sel_in      = out_q.sel_in;
  assign uop         = out_q.uop;
  assign branch_cond = out_q.branch_cond;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues expected bundles, monitor checks each cycle.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        global_disable = 1'b0;
  logic        num_to_rhs;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
  logic [4:0]  uop;
  logic        illegal;

  typedef struct packed {
    logic        ntr;
    logic [31:0] num;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  in;
    logic [4:0]  uop;
    logic [3:0]  bc;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_ill = 1'b0;

  decode_stage #(.FLUSH_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .global_disable (global_disable),
    .num_to_rhs     (num_to_rhs),
    .num            (num),
    .sel_p0         (sel_p0),
    .sel_p1         (sel_p1),
    .sel_in         (sel_in),
    .uop            (uop),
    .branch_cond    (branch_cond),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkw(input int u, input int bc, input int si, input int p0,
                                      input int p1, input int im, input int ex, input int i9);
    return {u[4:0], bc[3:0], si[3:0], p0[3:0], p1[3:0], im[0], ex[0], i9[8:0]};
  endfunction

  function automatic exp_t bnd(input logic ntr, input logic [31:0] n, input int p0, input int p1,
                               input int si, input int u, input int bc);
    exp_t e;
    e.ntr = ntr; e.num = n; e.p0 = p0[3:0]; e.p1 = p1[3:0]; e.in = si[3:0];
    e.uop = u[4:0]; e.bc = bc[3:0]; e.ill = 1'b0;
    return e;
  endfunction

  exp_t NOP;
  initial NOP = '0;

  // One driven cycle: inputs applied at negedge, expected post-edge bundle queued.
  task automatic step(input logic r, input logic v, input logic [31:0] w, input logic g,
                      input exp_t e, input string nm);
    exp_t ee;
    @(negedge clk);
    rst = r; instr_valid = v; instr = w; global_disable = g;
    ee = e;
    ee.ill = exp_ill;
    exp_q.push_back(ee);
    name_q.push_back(nm);
    #1;
    checks++;
    if (instr_ready !== ~r) begin
      errors++;
      $display("FAIL ready(%s): got %b want %b", nm, instr_ready, ~r);
    end
  endtask

  // Monitor: outputs update every cycle, so one expectation is consumed per edge.
  initial begin
    exp_t  got, want;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond, illegal};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got ntr=%b num=%h p0=%h p1=%h in=%h uop=%0d bc=%h ill=%b want ntr=%b num=%h p0=%h p1=%h in=%h uop=%0d bc=%h ill=%b",
                   nm, got.ntr, got.num, got.p0, got.p1, got.in, got.uop, got.bc, got.ill,
                   want.ntr, want.num, want.p0, want.p1, want.in, want.uop, want.bc, want.ill);
        end
      end
    end
  end

  initial begin
    step(1, 0, 32'h0, 0, NOP, "reset0");
    step(1, 1, 32'hFFFF_FFFF, 0, NOP, "reset1");

    // MOV r1,#0xCAFE long form
    step(0, 1, mkw(8, 0, 1, 0, 0, 1, 1, 0), 0, NOP, "movl_w0");
    step(0, 1, 32'h0000_CAFE, 0, bnd(1, 32'h0000_CAFE, 0, 0, 1, 8, 0), "movl_w1");
    // MOV r6,#1 short, ADD r4,r1,r2, B cond 3 with imm9 max
    step(0, 1, mkw(8, 0, 6, 0, 0, 1, 0, 1), 0, bnd(1, 32'd1, 0, 0, 6, 8, 0), "movs");
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, bnd(0, 32'd0, 1, 2, 4, 1, 0), "add");
    step(0, 1, mkw(9, 3, 0, 0, 0, 1, 0, 511), 0, bnd(1, 32'h1FF, 0, 0, 0, 9, 3), "b_imm9");

    // Idle gap: invalid words must not decode
    for (int i = 0; i < 3; i++) step(0, 0, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, NOP, "idle");

    // S_IMM with a 2-cycle valid gap
    step(0, 1, mkw(8, 0, 2, 0, 0, 1, 1, 0), 0, NOP, "gap_w0");
    step(0, 0, 32'h0, 0, NOP, "gap_idle0");
    step(0, 0, 32'h0, 0, NOP, "gap_idle1");
    step(0, 1, 32'h1234_5678, 0, bnd(1, 32'h1234_5678, 0, 0, 2, 8, 0), "gap_w1");

    // Flush after CMP r6,r7
    step(0, 1, mkw(5, 0, 0, 6, 7, 0, 0, 0), 0, bnd(0, 32'd0, 6, 7, 0, 5, 0), "cmp");
    step(0, 0, 32'h0, 1, NOP, "gd_pulse");
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, NOP, "flush_add");
    step(0, 1, mkw(3, 0, 5, 1, 2, 0, 0, 0), 0, NOP, "flush_and");
    step(0, 1, mkw(8, 0, 3, 0, 0, 1, 0, 5), 0, bnd(1, 32'd5, 0, 0, 3, 8, 0), "post_flush_mov");

    // Flush raised in S_IMM; idle cycle does not consume, ext word during flush is just dropped
    step(0, 1, mkw(8, 0, 1, 0, 0, 1, 1, 0), 0, NOP, "fimm_w0");
    step(0, 0, 32'h0, 1, NOP, "fimm_gd");
    step(0, 0, 32'h0, 0, NOP, "fimm_idle");
    step(0, 1, 32'h0000_CAFE, 0, NOP, "fimm_drop_imm");
    step(0, 1, mkw(8, 0, 7, 0, 0, 1, 1, 0), 0, NOP, "fimm_drop_ext");
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, bnd(0, 32'd0, 1, 2, 4, 1, 0), "fimm_add");

    // global_disable with a valid word in the same cycle
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 1, NOP, "gd_with_word");
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, NOP, "gd_drop0");
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, NOP, "gd_drop1");

    // Reset while in S_IMM
    step(0, 1, mkw(8, 0, 9, 0, 0, 1, 1, 0), 0, NOP, "rimm_w0");
    step(1, 0, 32'h0, 0, NOP, "rimm_rst0");
    step(1, 1, 32'h0000_CAFE, 0, NOP, "rimm_rst1");
    step(0, 1, 32'h4000_0000, 0, bnd(0, 32'd0, 0, 0, 0, 8, 0), "rimm_mov");

`ifdef DECODE_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
    step(0, 1, mkw(31, 0, 1, 2, 3, 0, 0, 0), 0, NOP, "ill_uop31");
    for (int i = 0; i < 5; i++)
      step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, bnd(0, 32'd0, 1, 2, 4, 1, 0), "ill_held");
    step(0, 1, mkw(6, 0, 1, 0, 0, 1, 1, 0), 0, NOP, "ill_ext_w0");
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, NOP, "ill_ext_w1");
    step(0, 1, mkw(3, 0, 5, 6, 7, 0, 0, 0), 0, bnd(0, 32'd0, 6, 7, 5, 3, 0), "ill_after");
    exp_ill = 1'b0;
    step(1, 0, 32'h0, 0, NOP, "ill_rst");
    step(0, 1, mkw(1, 0, 4, 1, 2, 0, 0, 0), 0, bnd(0, 32'd0, 1, 2, 4, 1, 0), "ill_clr_add");
`endif

    step(0, 0, 32'h0, 0, NOP, "tail");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
